calc_entry_fsm: RTL and testbench

Keypad entry controller for the BCD calculator. It sits directly upstream of the calculator ALU and turns single-cycle key strobes into the two 4-digit BCD operands and the operation select that drive the ALU. It captures the ALU's combinational result and sign into a result register, supports chained and repeated operations, and supplies a display value and negative flag.

---
 rtl/calc_entry_fsm.sv | 148 ++++++++++++++
 tb/tb_calc_entry_fsm.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Keypad entry controller for the BCD calculator: collects two 4-digit BCD operands
// and an operation from key strobes, then captures the ALU result for display.
module calc_entry_fsm (
   input  logic        clk,
   input  logic        clear_n,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic [15:0] alu_bcd,
   input  logic        alu_neg,
   output logic [15:0] bcd1,
   output logic [15:0] bcd2,
   output logic [3:0]  op_selected,
   output logic [15:0] disp_bcd,
   output logic        disp_neg,
   output logic        busy
);

   // state    | meaning
   // ENTER_A  | collecting operand A digits into bcd1
   // ENTER_B  | operation chosen, collecting operand B digits into bcd2
   // EXEC     | one cycle: operands stable, ALU result captured; keys dropped
   // RESULT   | result held for display; digit/op/'=' start, chain or repeat
   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      EXEC    = 2'd2,
      RESULT  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_EQ  = 4'hC;
   localparam logic [3:0] KEY_CLR = 4'hD;

   localparam logic [3:0] OP_NONE = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;

   state_t      state;
   logic [2:0]  cnt1;
   logic [2:0]  cnt2;
   logic [15:0] res_bcd;
   logic        res_neg;

   logic        is_digit;
   logic        is_op;
   logic        is_eq;
   logic        is_clr;
   logic        is_zero;
   logic [3:0]  key_op;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_op    = key_valid && ((key_code == KEY_ADD) || (key_code == KEY_SUB));
   assign is_eq    = key_valid && (key_code == KEY_EQ);
   assign is_clr   = key_valid && (key_code == KEY_CLR);
   assign is_zero  = (key_code == 4'd0);
   assign key_op   = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state       <= ENTER_A;
         bcd1        <= 16'h0000;
         bcd2        <= 16'h0000;
         op_selected <= OP_NONE;
         cnt1        <= 3'd0;
         cnt2        <= 3'd0;
         res_bcd     <= 16'h0000;
         res_neg     <= 1'b0;
      end else if (is_clr && (state != EXEC)) begin
         state       <= ENTER_A;
         bcd1        <= 16'h0000;
         bcd2        <= 16'h0000;
         op_selected <= OP_NONE;
         cnt1        <= 3'd0;
         cnt2        <= 3'd0;
         res_bcd     <= 16'h0000;
         res_neg     <= 1'b0;
      end else begin
         case (state)
            ENTER_A: begin
               // a zero with no digits yet is a leading zero: value stays 0, not counted
               if (is_digit) begin
                  if (!(cnt1 == 3'd0 && is_zero) && (cnt1 != 3'd4)) begin
                     bcd1 <= {bcd1[11:0], key_code};
                     cnt1 <= cnt1 + 3'd1;
                  end
               end else if (is_op) begin
                  op_selected <= key_op;
                  bcd2        <= 16'h0000;
                  cnt2        <= 3'd0;
                  state       <= ENTER_B;
               end
            end
            ENTER_B: begin
               if (is_digit) begin
                  if (!(cnt2 == 3'd0 && is_zero) && (cnt2 != 3'd4)) begin
                     bcd2 <= {bcd2[11:0], key_code};
                     cnt2 <= cnt2 + 3'd1;
                  end
               end else if (is_op) begin
                  op_selected <= key_op;
               end else if (is_eq) begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               res_bcd <= alu_bcd;
               res_neg <= alu_neg;
               state   <= RESULT;
            end
            RESULT: begin
               if (is_digit) begin
                  bcd1        <= {12'h000, key_code};
                  cnt1        <= is_zero ? 3'd0 : 3'd1;
                  bcd2        <= 16'h0000;
                  cnt2        <= 3'd0;
                  op_selected <= OP_NONE;
                  state       <= ENTER_A;
               end else if (is_op) begin
                  // a negative result cannot seed operand A; chain from zero instead
                  bcd1        <= res_neg ? 16'h0000 : res_bcd;
                  op_selected <= key_op;
                  bcd2        <= 16'h0000;
                  cnt2        <= 3'd0;
                  state       <= ENTER_B;
               end else if (is_eq && !res_neg) begin
                  bcd1  <= res_bcd;
                  state <= EXEC;
               end
            end
            default: state <= ENTER_A;
         endcase
      end
   end

   always_comb begin
      disp_bcd = res_bcd;
      case (state)
         ENTER_A: disp_bcd = bcd1;
         ENTER_B: disp_bcd = bcd2;
         default: disp_bcd = res_bcd;
      endcase
   end

   assign disp_neg = res_neg && (state == RESULT);
   assign busy     = (state == EXEC);

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: behavioural BCD ALU, key-press tasks, and a queue of
// expected results pushed at '=' and popped when the result appears.
module tb_calc_entry_fsm;

   localparam logic [3:0] K_ADD = 4'hA;
   localparam logic [3:0] K_SUB = 4'hB;
   localparam logic [3:0] K_EQ  = 4'hC;
   localparam logic [3:0] K_CLR = 4'hD;

   logic        clk;
   logic        clear_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] alu_bcd;
   logic        alu_neg;
   logic [15:0] bcd1;
   logic [15:0] bcd2;
   logic [3:0]  op_selected;
   logic [15:0] disp_bcd;
   logic        disp_neg;
   logic        busy;

   int total = 0;
   int bad   = 0;
   logic [16:0] exp_q[$];

   calc_entry_fsm dut (
      .clk         (clk),
      .clear_n     (clear_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .alu_bcd     (alu_bcd),
      .alu_neg     (alu_neg),
      .bcd1        (bcd1),
      .bcd2        (bcd2),
      .op_selected (op_selected),
      .disp_bcd    (disp_bcd),
      .disp_neg    (disp_neg),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [15:0] v);
      return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [15:0] int2bcd(input int x);
      logic [15:0] r;
      r[15:12] = 4'((x / 1000) % 10);
      r[11:8]  = 4'((x / 100) % 10);
      r[7:4]   = 4'((x / 10) % 10);
      r[3:0]   = 4'(x % 10);
      return r;
   endfunction

   int alu_a, alu_b, alu_r;
   always_comb begin
      alu_a   = bcd2int(bcd1);
      alu_b   = bcd2int(bcd2);
      alu_r   = alu_a;
      alu_neg = 1'b0;
      case (op_selected)
         4'b0001: alu_r = (alu_a + alu_b) % 10000;
         4'b0010: begin
            if (alu_a >= alu_b) alu_r = alu_a - alu_b;
            else begin
               alu_r   = alu_b - alu_a;
               alu_neg = 1'b1;
            end
         end
         default: alu_r = alu_a;
      endcase
      alu_bcd = int2bcd(alu_r);
   end

   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic press_eq(input logic [15:0] exp_bcd, input logic exp_neg);
      int n;
      logic [16:0] e;
      exp_q.push_back({exp_neg, exp_bcd});
      press(K_EQ);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL eq_busy: busy=%b want 1", busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 4) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL eq_timeout: busy still %b after %0d cycles", busy, n);
      end else if ({disp_neg, disp_bcd} !== e) begin
         bad++;
         $display("FAIL eq_result: neg=%b disp=%h want neg=%b disp=%h", disp_neg, disp_bcd, e[16], e[15:0]);
      end
   endtask

   task automatic test_reset();
      clear_n   = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      #12;
      total++;
      if ({bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy} !== 54'd0 || dut.state !== 2'd0) begin
         bad++;
         $display("FAIL reset: bcd1=%h bcd2=%h op=%b disp=%h neg=%b busy=%b state=%0d want all 0",
                  bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy, dut.state);
      end
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   task automatic test_add();
      press(4'd1); press(4'd2); press(K_ADD);
      total++;
      if ({bcd1, op_selected, disp_bcd} !== {16'h0012, 4'b0001, 16'h0000}) begin
         bad++;
         $display("FAIL add_op: bcd1=%h op=%b disp=%h want 0012 0001 0000", bcd1, op_selected, disp_bcd);
      end
      press(4'd3); press(4'd4);
      total++;
      if ({bcd2, disp_bcd} !== {16'h0034, 16'h0034}) begin
         bad++;
         $display("FAIL add_b: bcd2=%h disp=%h want 0034 0034", bcd2, disp_bcd);
      end
      press_eq(16'h0046, 1'b0);
      total++;
      if ({bcd1, bcd2, op_selected} !== {16'h0012, 16'h0034, 4'b0001}) begin
         bad++;
         $display("FAIL add_operands: bcd1=%h bcd2=%h op=%b want 0012 0034 0001", bcd1, bcd2, op_selected);
      end
   endtask

   task automatic test_repeat();
      press(K_ADD);
      total++;
      if ({bcd1, bcd2, op_selected} !== {16'h0046, 16'h0000, 4'b0001} || dut.state !== 2'd1) begin
         bad++;
         $display("FAIL chain: bcd1=%h bcd2=%h op=%b state=%0d want 0046 0000 0001 1",
                  bcd1, bcd2, op_selected, dut.state);
      end
      press(4'd4);
      press_eq(16'h0050, 1'b0);
      press_eq(16'h0054, 1'b0);
      total++;
      if ({bcd1, bcd2} !== {16'h0050, 16'h0004}) begin
         bad++;
         $display("FAIL repeat_operands: bcd1=%h bcd2=%h want 0050 0004", bcd1, bcd2);
      end
      press(4'd7);
      total++;
      if ({bcd1, bcd2, op_selected, disp_bcd, disp_neg} !== {16'h0007, 16'h0000, 4'b0000, 16'h0007, 1'b0}
          || dut.state !== 2'd0) begin
         bad++;
         $display("FAIL new_calc: bcd1=%h bcd2=%h op=%b disp=%h neg=%b state=%0d want 0007 0000 0000 0007 0 0",
                  bcd1, bcd2, op_selected, disp_bcd, disp_neg, dut.state);
      end
   endtask

   task automatic test_sub_negative();
      press(K_CLR); press(4'd5); press(K_SUB); press(4'd9);
      total++;
      if (op_selected !== 4'b0010) begin
         bad++;
         $display("FAIL sub_op: op=%b want 0010", op_selected);
      end
      press_eq(16'h0004, 1'b1);
      press(K_EQ);
      total++;
      if ({busy, disp_neg, disp_bcd, bcd1} !== {1'b0, 1'b1, 16'h0004, 16'h0005} || dut.state !== 2'd3) begin
         bad++;
         $display("FAIL neg_eq_ignored: busy=%b neg=%b disp=%h bcd1=%h state=%0d want 0 1 0004 0005 3",
                  busy, disp_neg, disp_bcd, bcd1, dut.state);
      end
      press(K_ADD);
      total++;
      if ({bcd1, bcd2, op_selected, disp_neg} !== {16'h0000, 16'h0000, 4'b0001, 1'b0} || dut.state !== 2'd1) begin
         bad++;
         $display("FAIL neg_chain: bcd1=%h bcd2=%h op=%b neg=%b state=%0d want 0000 0000 0001 0 1",
                  bcd1, bcd2, op_selected, disp_neg, dut.state);
      end
   endtask

   task automatic test_leading_zero();
      press(K_CLR); press(4'd0); press(4'd0);
      total++;
      if (bcd1 !== 16'h0000 || dut.cnt1 !== 3'd0) begin
         bad++;
         $display("FAIL lead_zero: bcd1=%h cnt1=%0d want 0000 0", bcd1, dut.cnt1);
      end
      press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
      total++;
      if (bcd1 !== 16'h1234 || dut.cnt1 !== 3'd4 || disp_bcd !== 16'h1234) begin
         bad++;
         $display("FAIL digit_limit: bcd1=%h cnt1=%0d disp=%h want 1234 4 1234", bcd1, dut.cnt1, disp_bcd);
      end
   endtask

   task automatic test_back_to_back();
      press(K_CLR);
      @(negedge clk); key_valid = 1'b1; key_code = 4'd9;
      @(negedge clk); key_code = 4'd8;
      @(negedge clk); key_code = 4'd7;
      @(negedge clk); key_valid = 1'b0;
      total++;
      if (bcd1 !== 16'h0987 || dut.cnt1 !== 3'd3) begin
         bad++;
         $display("FAIL back_to_back: bcd1=%h cnt1=%0d want 0987 3", bcd1, dut.cnt1);
      end
   endtask

   task automatic test_ignored_codes();
      press(4'hE); press(4'hF); press(K_EQ);
      total++;
      if ({bcd1, op_selected, busy} !== {16'h0987, 4'b0000, 1'b0} || dut.state !== 2'd0) begin
         bad++;
         $display("FAIL ignored_keys: bcd1=%h op=%b busy=%b state=%0d want 0987 0000 0 0",
                  bcd1, op_selected, busy, dut.state);
      end
   endtask

   task automatic test_exec_drop();
      logic [16:0] e;
      press(K_CLR); press(4'd1); press(K_ADD); press(4'd2);
      exp_q.push_back({1'b0, 16'h0003});
      @(negedge clk); key_valid = 1'b1; key_code = K_EQ;
      @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL exec_busy: busy=%b want 1", busy);
      end
      key_code = 4'd9;
      @(negedge clk); key_valid = 1'b0;
      e = exp_q.pop_front();
      total++;
      if ({bcd1, bcd2, op_selected, busy} !== {16'h0001, 16'h0002, 4'b0001, 1'b0} || dut.state !== 2'd3) begin
         bad++;
         $display("FAIL exec_drop: bcd1=%h bcd2=%h op=%b busy=%b state=%0d want 0001 0002 0001 0 3",
                  bcd1, bcd2, op_selected, busy, dut.state);
      end
      total++;
      if ({disp_neg, disp_bcd} !== e) begin
         bad++;
         $display("FAIL exec_result: neg=%b disp=%h want neg=%b disp=%h", disp_neg, disp_bcd, e[16], e[15:0]);
      end
   endtask

   task automatic test_async_clear();
      press(K_CLR); press(4'd1); press(K_ADD); press(4'd3);
      total++;
      if (bcd2 !== 16'h0003) begin
         bad++;
         $display("FAIL pre_clear: bcd2=%h want 0003", bcd2);
      end
      #2 clear_n = 1'b0;
      #1;
      total++;
      if ({bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy} !== 54'd0 || dut.state !== 2'd0) begin
         bad++;
         $display("FAIL async_clear: bcd1=%h bcd2=%h op=%b disp=%h neg=%b busy=%b state=%0d want all 0",
                  bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy, dut.state);
      end
      @(negedge clk); clear_n = 1'b1;
      press(4'd1); press(K_ADD); press(4'd3);
      press(K_CLR);
      total++;
      if ({bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy} !== 54'd0 || dut.state !== 2'd0) begin
         bad++;
         $display("FAIL key_clear: bcd1=%h bcd2=%h op=%b disp=%h neg=%b busy=%b state=%0d want all 0",
                  bcd1, bcd2, op_selected, disp_bcd, disp_neg, busy, dut.state);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_repeat();
      test_sub_negative();
      test_leading_zero();
      test_back_to_back();
      test_ignored_codes();
      test_exec_drop();
      test_async_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
